// File: rtl/prefetcher_pkg.sv
// Shared types and constants for the prefetcher's DDR-side read responder.
package prefetcher_pkg;

  localparam logic [1:0] R_RESP_OKAY   = 2'b00;
  localparam logic [1:0] R_RESP_SLVERR = 2'b10;

  localparam int PF_ADDR_BITS = 16;
  localparam int PF_TID_WIDTH = 8;
  localparam int PF_LEN_WIDTH = 8;

  typedef struct packed {
    logic [PF_TID_WIDTH-1:0] id;
    logic [PF_ADDR_BITS-1:0] addr;
    logic [PF_LEN_WIDTH-1:0] len;
  } rd_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } rd_state_e;

endpackage

// File: rtl/prefetcher_rd_fifo.sv
// Synchronous request FIFO with full/empty/count; head is read combinationally.
module prefetcher_rd_fifo
  import prefetcher_pkg::*;
#(
  parameter type entry_t   = rd_req_t,
  parameter int  LOG_DEPTH = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               push,
  input  entry_t             push_data,
  input  logic               pop,
  output entry_t             head,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  entry_t               mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prefetcher_rd_responder.sv
// AXI read responder: queues AR bursts, waits a programmable latency, then returns
// INCR beats whose data is the beat address, with throttle and SLVERR-window knobs.
module prefetcher_rd_responder
  import prefetcher_pkg::*;
#(
  parameter  int ADDR_BITS            = 16,
  parameter  int TID_WIDTH            = 8,
  parameter  int BURST_LEN_WIDTH      = 8,
  parameter  int LOG_BLOCK_DATA_BYTES = 0,
  parameter  int LOG_QUEUE_SIZE       = 2,
  parameter  int LAT_WIDTH            = 6,
  localparam int DATA_WIDTH           = 8 << LOG_BLOCK_DATA_BYTES
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       s_ar_valid,
  output logic                       s_ar_ready,
  input  logic [ADDR_BITS-1:0]       s_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [TID_WIDTH-1:0]       s_ar_id,
  output logic                       s_r_valid,
  input  logic                       s_r_ready,
  output logic [DATA_WIDTH-1:0]      s_r_data,
  output logic [TID_WIDTH-1:0]       s_r_id,
  output logic                       s_r_last,
  output logic [1:0]                 s_r_resp,
  input  logic [LAT_WIDTH-1:0]       cfg_latency,
  input  logic [LAT_WIDTH-1:0]       cfg_throttle,
  input  logic [ADDR_BITS-1:0]       cfg_errBase,
  input  logic [ADDR_BITS-1:0]       cfg_errLimit,
  output logic [LOG_QUEUE_SIZE:0]    outstanding
);

  localparam int                   CW        = LOG_QUEUE_SIZE + 1;
  localparam int                   QDEPTH    = 1 << LOG_QUEUE_SIZE;
  localparam logic [ADDR_BITS-1:0] BEAT_STEP = ADDR_BITS'(1 << LOG_BLOCK_DATA_BYTES);

  typedef struct packed {
    logic [TID_WIDTH-1:0]       id;
    logic [ADDR_BITS-1:0]       addr;
    logic [BURST_LEN_WIDTH-1:0] len;
  } req_t;

  req_t                       push_req;
  req_t                       head;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [CW-1:0]              count_nxt;
  rd_state_e                  state;
  logic [ADDR_BITS-1:0]       beat_addr;
  logic [ADDR_BITS-1:0]       addr_nxt;
  logic [BURST_LEN_WIDTH-1:0] act_len;
  logic [TID_WIDTH-1:0]       act_id;
  logic [1:0]                 act_resp;
  logic [BURST_LEN_WIDTH:0]   beat;
  logic [BURST_LEN_WIDTH:0]   beat_nxt;
  logic [LAT_WIDTH-1:0]       lat_cnt;
  logic [LAT_WIDTH-1:0]       thr_cnt;
  logic [LAT_WIDTH-1:0]       thr_nxt;
  logic                       r_fire;
  logic                       last_fire;
  logic                       bubble;

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_BITS-1:0] a);
    return DATA_WIDTH'(a);
  endfunction

  function automatic logic [1:0] resp_for(input logic [ADDR_BITS-1:0] a,
                                          input logic [ADDR_BITS-1:0] base,
                                          input logic [ADDR_BITS-1:0] limit);
    if ((base < limit) && (a >= base) && (a < limit)) return R_RESP_SLVERR;
    return R_RESP_OKAY;
  endfunction

  prefetcher_rd_fifo #(
    .entry_t   (req_t),
    .LOG_DEPTH (LOG_QUEUE_SIZE)
  ) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    push_req.id   = s_ar_id;
    push_req.addr = s_ar_addr;
    push_req.len  = s_ar_len;
    r_fire        = (state == BURST) && s_r_valid && s_r_ready;
    last_fire     = r_fire && s_r_last;
    pop           = !fifo_empty && ((state == IDLE) || last_fire);
    push          = s_ar_valid && s_ar_ready && (!fifo_full || pop);
    count_nxt     = fifo_count + CW'(push) - CW'(pop);
    beat_nxt      = beat + 1'b1;
    addr_nxt      = beat_addr + BEAT_STEP;
    thr_nxt       = thr_cnt + 1'b1;
    bubble        = (cfg_throttle != '0) && (thr_nxt >= cfg_throttle);
  end

  assign outstanding = fifo_count + CW'(state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= IDLE;
      s_ar_ready <= 1'b0;
      s_r_valid  <= 1'b0;
      s_r_last   <= 1'b0;
      s_r_data   <= '0;
      s_r_id     <= '0;
      s_r_resp   <= R_RESP_OKAY;
      beat_addr  <= '0;
      act_len    <= '0;
      act_id     <= '0;
      act_resp   <= R_RESP_OKAY;
      beat       <= '0;
      lat_cnt    <= '0;
      thr_cnt    <= '0;
    end else begin
      s_ar_ready <= (count_nxt != CW'(QDEPTH));

      if (cfg_throttle == '0) thr_cnt <= '0;
      else if (r_fire)        thr_cnt <= bubble ? '0 : thr_nxt;

      // Pop loads the active burst; from BURST this skips IDLE entirely.
      if (pop) begin
        state     <= WAIT;
        beat_addr <= head.addr;
        act_len   <= head.len;
        act_id    <= head.id;
        act_resp  <= resp_for(head.addr, cfg_errBase, cfg_errLimit);
        beat      <= '0;
        lat_cnt   <= cfg_latency;
      end

      case (state)
        IDLE: ;
        WAIT: begin
          if (lat_cnt == '0) begin
            state     <= BURST;
            s_r_valid <= 1'b1;
            s_r_data  <= beat_data(beat_addr);
            s_r_id    <= act_id;
            s_r_last  <= (act_len == '0);
            s_r_resp  <= act_resp;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        BURST: begin
          if (last_fire) begin
            s_r_valid <= 1'b0;
            s_r_last  <= 1'b0;
            if (!pop) state <= IDLE;
          end else if (r_fire) begin
            beat      <= beat_nxt;
            beat_addr <= addr_nxt;
            s_r_data  <= beat_data(addr_nxt);
            s_r_last  <= (beat_nxt == {1'b0, act_len});
            s_r_valid <= !bubble;
          end else if (!s_r_valid) begin
            s_r_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
